// File: rtl/spi_mem_target.sv
// SPI mode-0 target that behaves like a small serial SRAM (READ 0x03 / WRITE 0x02, 24-bit address).
// Storage is an on-chip byte array with a host-side backdoor read/write port.
module spi_mem_target #(
    parameter int MEM_DEPTH   = 256,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    output logic          busy,
    output logic          cmd_error,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [7:0]    bd_wdata,
    output logic [7:0]    bd_rdata
);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_RD,
        ADDR_WR,
        RD,
        WR,
        IGNORE
    } state_t;

    state_t         state_reg, state_next;
    logic           sclk_s, cs_n_s, mosi_s;
    logic           sclk_prev_reg, cs_n_prev_reg;
    logic [4:0]     bit_cnt_reg;
    logic [7:0]     shift_reg;
    logic [AW-1:0]  addr_reg;
    logic [7:0]     tx_shift_reg;
    logic           miso_reg;
    logic           cmd_error_reg, cmd_error_next;
    logic [7:0]     bd_rdata_reg;

    logic           sclk_rise, sclk_fall;
    logic           spi_we;
    logic [7:0]     spi_wdata;
    logic [AW-1:0]  addr_shift_in, addr_inc, rd_addr;
    logic           tx_load;

    logic [7:0]     mem [MEM_DEPTH];

    // Synchroniser chain; each stage carries {sclk, cs_n, mosi}, idling as cs_n high.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= 3'b010;
                    else        q_reg <= {sclk, cs_n, mosi};
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= 3'b010;
                    else        q_reg <= g_sync[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign {sclk_s, cs_n_s, mosi_s} = g_sync[SYNC_STAGES-1].q_reg;

    assign sclk_rise     = sclk_s & ~sclk_prev_reg;
    assign sclk_fall     = ~sclk_s & sclk_prev_reg;
    assign spi_wdata     = {shift_reg[6:0], mosi_s};
    assign addr_shift_in = {addr_reg[AW-2:0], mosi_s};
    assign addr_inc      = addr_reg + AW'(1);

    always_comb begin
        state_next     = state_reg;
        cmd_error_next = 1'b0;
        spi_we         = 1'b0;
        tx_load        = 1'b0;
        rd_addr        = addr_inc;
        // A deasserted chip select overrides any sclk edge seen in the same cycle.
        if (cs_n_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cs_n_prev_reg) state_next = CMD;
                end
                CMD: begin
                    if (sclk_rise && bit_cnt_reg == 5'd7) begin
                        if (spi_wdata == OP_READ) begin
                            state_next = ADDR_RD;
                        end else if (spi_wdata == OP_WRITE) begin
                            state_next = ADDR_WR;
                        end else begin
                            state_next     = IGNORE;
                            cmd_error_next = 1'b1;
                        end
                    end
                end
                ADDR_RD: begin
                    if (sclk_rise && bit_cnt_reg == 5'd23) begin
                        state_next = RD;
                        tx_load    = 1'b1;
                        rd_addr    = addr_shift_in;
                    end
                end
                ADDR_WR: begin
                    if (sclk_rise && bit_cnt_reg == 5'd23) state_next = WR;
                end
                RD: begin
                    if (sclk_rise && bit_cnt_reg == 5'd7) tx_load = 1'b1;
                end
                WR: begin
                    if (sclk_rise && bit_cnt_reg == 5'd7) spi_we = 1'b1;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sclk_prev_reg <= 1'b0;
            cs_n_prev_reg <= 1'b1;
            bit_cnt_reg   <= 5'd0;
            shift_reg     <= 8'd0;
            addr_reg      <= '0;
            tx_shift_reg  <= 8'd0;
            miso_reg      <= 1'b0;
            cmd_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sclk_prev_reg <= sclk_s;
            cs_n_prev_reg <= cs_n_s;
            cmd_error_reg <= cmd_error_next;

            if (tx_load)
                tx_shift_reg <= mem[rd_addr];
            else if (!cs_n_s && state_reg == RD && sclk_fall)
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};

            if (cs_n_s) begin
                bit_cnt_reg <= 5'd0;
                shift_reg   <= 8'd0;
                miso_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: bit_cnt_reg <= 5'd0;
                    CMD, WR: begin
                        if (sclk_rise) begin
                            shift_reg   <= spi_wdata;
                            bit_cnt_reg <= (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
                            if (state_reg == WR && bit_cnt_reg == 5'd7) addr_reg <= addr_inc;
                        end
                    end
                    ADDR_RD, ADDR_WR: begin
                        if (sclk_rise) begin
                            addr_reg    <= addr_shift_in;
                            bit_cnt_reg <= (bit_cnt_reg == 5'd23) ? 5'd0 : bit_cnt_reg + 5'd1;
                        end
                    end
                    RD: begin
                        if (sclk_fall) miso_reg <= tx_shift_reg[7];
                        if (sclk_rise) begin
                            bit_cnt_reg <= (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) addr_reg <= addr_inc;
                        end
                    end
                    default: bit_cnt_reg <= bit_cnt_reg;
                endcase
            end
        end
    end

    // Two write ports; the SPI write is issued last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (bd_we)  mem[bd_addr]  <= bd_wdata;
        if (spi_we) mem[addr_reg] <= spi_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bd_rdata_reg <= 8'd0;
        else        bd_rdata_reg <= mem[bd_addr];
    end

    assign miso_oe   = (state_reg == RD) && !cs_n_s;
    assign miso      = miso_oe & miso_reg;
    assign busy      = ~cs_n_s;
    assign cmd_error = cmd_error_reg;
    assign bd_rdata  = bd_rdata_reg;

endmodule
